eu_cache_rd_arbiter: RTL

- Shares the exec-unit cache's single interconnect operand-read port (addr in; data/valid out; ready in) between N_REQ foreign requesters, such as other exec units' operand fetch paths.
- Uses round-robin arbitration with one outstanding transaction.
- Latches the winner's address, drives the cache read handshake, and returns the data only to the granted requester.
- Sits between the interconnect requester fan-in and the cache's r0 port.

---
 rtl/eu_cache_rd_arbiter_pkg.sv | 19 +
 rtl/eu_cache_rd_arbiter_if.sv | 32 +++
 rtl/eu_cache_rr_pick.sv | 41 ++++
 rtl/eu_cache_rd_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/eu_cache_rd_arbiter_pkg.sv
// Shared types and default widths for the exec-unit cache read-port arbiter.
package eu_cache_rd_arbiter_pkg;

  localparam int EU_N_REQ  = 4;
  localparam int EU_ADDR_W = 8;
  localparam int EU_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/eu_cache_rd_arbiter_if.sv
// Requester fan-in plus cache r0 port bundle; slave = arbiter side, master = environment side.
interface eu_cache_rd_arbiter_if
  import eu_cache_rd_arbiter_pkg::*;
#(
  parameter int N_REQ  = EU_N_REQ,
  parameter int ADDR_W = EU_ADDR_W,
  parameter int DATA_W = EU_DATA_W
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic                    rsp_err;
  logic [N_REQ-1:0]        rsp_ready;
  logic [ADDR_W-1:0]       cache_raddr;
  logic                    cache_rready;
  logic [DATA_W-1:0]       cache_rdata;
  logic                    cache_rvalid;

  modport slave (
    input  req_valid, req_addr, rsp_ready, cache_rdata, cache_rvalid,
    output req_ready, rsp_valid, rsp_data, rsp_err, cache_raddr, cache_rready
  );

  modport master (
    output req_valid, req_addr, rsp_ready, cache_rdata, cache_rvalid,
    input  req_ready, rsp_valid, rsp_data, rsp_err, cache_raddr, cache_rready
  );

endinterface

// File: rtl/eu_cache_rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping modulo N_REQ.
module eu_cache_rr_pick
  import eu_cache_rd_arbiter_pkg::*;
#(
  parameter int N_REQ = EU_N_REQ,
  localparam int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_any
);

  logic [IDX_W:0]   w_sum     [N_REQ];
  logic [IDX_W-1:0] w_cand    [N_REQ];
  logic [IDX_W-1:0] w_idx_acc [N_REQ+1];
  logic [N_REQ-1:0] w_hit;
  logic [N_REQ-1:0] w_first;
  logic [N_REQ:0]   w_seen;

  assign w_seen[0]    = 1'b0;
  assign w_idx_acc[0] = '0;

  // Slot gi of the rotated view is requester (i_ptr + gi) mod N_REQ; lowest slot wins.
  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_slot
    assign w_sum[gi]  = {1'b0, i_ptr} + (IDX_W+1)'(gi);
    assign w_cand[gi] = (w_sum[gi] >= (IDX_W+1)'(N_REQ)) ?
                        IDX_W'(w_sum[gi] - (IDX_W+1)'(N_REQ)) : IDX_W'(w_sum[gi]);
    assign w_hit[gi]       = i_req[w_cand[gi]];
    assign w_first[gi]     = w_hit[gi] & ~w_seen[gi];
    assign w_seen[gi+1]    = w_seen[gi] | w_hit[gi];
    assign w_idx_acc[gi+1] = w_idx_acc[gi] | (w_first[gi] ? w_cand[gi] : '0);
  end

  assign o_any     = w_seen[N_REQ];
  assign o_gnt_idx = w_idx_acc[N_REQ];
  assign o_gnt     = o_any ? (N_REQ'(1) << o_gnt_idx) : '0;

endmodule

// File: rtl/eu_cache_rd_arbiter.sv
// Round-robin arbiter sharing the exec-unit cache r0 read port, one transaction in flight.
// Optional ISSUE timeout abort is enabled by defining EU_CACHE_RDARB_TIMEOUT_EN.
module eu_cache_rd_arbiter
  import eu_cache_rd_arbiter_pkg::*;
#(
  parameter int N_REQ          = EU_N_REQ,
  parameter int ADDR_W         = EU_ADDR_W,
  parameter int DATA_W         = EU_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                  clk,
  input logic                  reset,
  eu_cache_rd_arbiter_if.slave bus
);

  localparam int IDX_W = idx_w(N_REQ);

  arb_state_e        r_state, w_state_next;
  logic [IDX_W-1:0]  r_gnt_idx, w_gnt_idx_next;
  logic [IDX_W-1:0]  r_rr_ptr, w_rr_ptr_next;
  logic [ADDR_W-1:0] r_addr_q, w_addr_q_next;
  logic [DATA_W-1:0] r_data_q, w_data_q_next;

  logic [N_REQ-1:0]  w_pick_gnt;
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_pick_any;
  logic [ADDR_W-1:0] w_req_addr [N_REQ];

  logic [N_REQ-1:0]  w_req_ready;
  logic [N_REQ-1:0]  w_rsp_valid;
  logic [DATA_W-1:0] w_rsp_data;
  logic [ADDR_W-1:0] w_cache_raddr;
  logic              w_cache_rready;

  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_addr
    assign w_req_addr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
  end

  eu_cache_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req     (bus.req_valid),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_pick_gnt),
    .o_gnt_idx (w_pick_idx),
    .o_any     (w_pick_any)
  );

`ifdef EU_CACHE_RDARB_TIMEOUT_EN
  localparam int TO_W = idx_w(TIMEOUT_CYCLES);

  logic            r_err_q, w_err_q_next;
  logic [TO_W-1:0] r_to_cnt;
  logic            w_to_hit;

  assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Outside ISSUE the counter sits at zero, so it is clear on every ISSUE entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt <= '0;
      r_err_q  <= 1'b0;
    end else begin
      r_err_q <= w_err_q_next;
      if (r_state != ST_ISSUE)
        r_to_cnt <= '0;
      else if (!bus.cache_rvalid)
        r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign bus.rsp_err = (r_state == ST_RESP) ? r_err_q : 1'b0;
`else
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_gnt_idx <= '0;
      r_rr_ptr  <= '0;
      r_addr_q  <= '0;
      r_data_q  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_gnt_idx <= w_gnt_idx_next;
      r_rr_ptr  <= w_rr_ptr_next;
      r_addr_q  <= w_addr_q_next;
      r_data_q  <= w_data_q_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_gnt_idx_next = r_gnt_idx;
    w_rr_ptr_next  = r_rr_ptr;
    w_addr_q_next  = r_addr_q;
    w_data_q_next  = r_data_q;
`ifdef EU_CACHE_RDARB_TIMEOUT_EN
    w_err_q_next   = r_err_q;
`endif
    w_req_ready    = '0;
    w_rsp_valid    = '0;
    w_rsp_data     = '0;
    w_cache_raddr  = '0;
    w_cache_rready = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_req_ready    = w_pick_gnt;
          w_addr_q_next  = w_req_addr[w_pick_idx];
          w_gnt_idx_next = w_pick_idx;
          w_state_next   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_cache_raddr  = r_addr_q;
        w_cache_rready = 1'b1;
        // A late cache_rvalid beats the timeout in the same cycle.
        if (bus.cache_rvalid) begin
          w_data_q_next = bus.cache_rdata;
`ifdef EU_CACHE_RDARB_TIMEOUT_EN
          w_err_q_next  = 1'b0;
`endif
          w_state_next  = ST_RESP;
        end
`ifdef EU_CACHE_RDARB_TIMEOUT_EN
        else if (w_to_hit) begin
          w_data_q_next = '0;
          w_err_q_next  = 1'b1;
          w_state_next  = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        w_rsp_valid = N_REQ'(1) << r_gnt_idx;
        w_rsp_data  = r_data_q;
        if (bus.rsp_ready[r_gnt_idx]) begin
          w_state_next  = ST_IDLE;
          w_rr_ptr_next = (r_gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The IDLE accept is combinational, so it must be masked while reset is held.
  assign bus.req_ready    = reset ? '0 : w_req_ready;
  assign bus.rsp_valid    = w_rsp_valid;
  assign bus.rsp_data     = w_rsp_data;
  assign bus.cache_raddr  = w_cache_raddr;
  assign bus.cache_rready = w_cache_rready;

endmodule
